// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and the stages that sit on its ports.
package fifo_pkg;

   localparam int unsigned FIFO_DSIZE = 8;

   // Read-side packer: FILL accumulates entries, FLUSH closes a partial word.
   typedef enum logic {FILL, FLUSH} pk_state_t;

endpackage

// File: rtl/fifo_out_stage.sv
// Valid/ready holding register for a data word with lane count and last flag.
// A load is only legal when can_load is high; the word then stays stable until accepted.
module fifo_out_stage #(
   parameter int unsigned W     = 32,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   output logic             can_load,
   input  logic [W-1:0]     in_data,
   input  logic [CNT_W-1:0] in_count,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_last
);

   logic             valid_q, valid_d;
   logic [W-1:0]     data_q, data_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             last_q, last_d;

   assign can_load  = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_count = count_q;
   assign out_last  = last_q;

   // Next-state: load a new word, or drop valid once the current word is taken.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      count_d = count_q;
      last_d  = last_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = in_data;
         count_d = in_count;
         last_d  = in_last;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // Holding register, cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         count_q <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         count_q <= count_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side drain stage of the async FIFO: pops DSIZE-bit entries and packs NBYTES of
// them into one output word; a flush pulse closes a partially filled word.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int unsigned DSIZE  = FIFO_DSIZE,
   parameter int unsigned NBYTES = 4,
   parameter int unsigned CNT_W  = $clog2(NBYTES + 1)
) (
   input  logic                    rclk,
   input  logic                    rrst,
   input  logic                    rempty,
   input  logic [DSIZE-1:0]        rdata,
   output logic                    rinc,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DSIZE*NBYTES-1:0] out_data,
   output logic [CNT_W-1:0]        out_count,
   output logic                    out_last
);

   logic [DSIZE*NBYTES-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        acc_cnt_q, acc_cnt_d;
   pk_state_t               state_q, state_d;

   logic can_load;
   logic acc_full;
   logic acc_empty;
   logic xfer;
   logic pop;

   assign acc_full  = (acc_cnt_q == CNT_W'(NBYTES));
   assign acc_empty = (acc_cnt_q == '0);
   assign rinc      = pop;

   // FSM state register.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: an empty accumulator leaves FLUSH without emitting a word.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FILL:  if (flush) state_d = FLUSH;
         FLUSH: if (xfer || acc_empty) state_d = FILL;
      endcase
   end

   // FSM outputs: word transfer and FIFO pop; rrst gates rinc without waiting for a clock.
   always_comb begin
      xfer = can_load && (acc_full || (state_q == FLUSH && !acc_empty));
      pop  = !rrst && !rempty && (state_q == FILL) && (!acc_full || xfer);
   end

   // Accumulator next state: a transfer empties it, so a same-cycle pop lands in lane 0.
   // Clearing on transfer keeps unused lanes of a flushed word at zero.
   always_comb begin
      acc_d     = acc_q;
      acc_cnt_d = acc_cnt_q;
      if (xfer) begin
         acc_d     = '0;
         acc_cnt_d = '0;
      end
      if (pop) begin
         for (int i = 0; i < int'(NBYTES); i++) begin
            if (acc_cnt_d == CNT_W'(i)) acc_d[i*DSIZE +: DSIZE] = rdata;
         end
         acc_cnt_d = acc_cnt_d + CNT_W'(1);
      end
   end

   // Accumulator register.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         acc_q     <= '0;
         acc_cnt_q <= '0;
      end else begin
         acc_q     <= acc_d;
         acc_cnt_q <= acc_cnt_d;
      end
   end

   fifo_out_stage #(
      .W     (DSIZE * NBYTES),
      .CNT_W (CNT_W)
   ) u_out_stage (
      .clk       (rclk),
      .rst       (rrst),
      .load      (xfer),
      .can_load  (can_load),
      .in_data   (acc_q),
      .in_count  (acc_cnt_q),
      .in_last   (state_q == FLUSH),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .out_last  (out_last)
   );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: a FIFO model feeds the DUT, a byte-stream
// reference model predicts words into a scoreboard, and a monitor checks accepted words.
module tb_fifo_rd_packer;

   localparam int DSIZE  = 8;
   localparam int NBYTES = 4;
   localparam int CNT_W  = 3;

   logic                    rclk = 1'b0;
   logic                    rrst = 1'b1;
   logic                    rempty = 1'b0;
   logic [DSIZE-1:0]        rdata = '0;
   logic                    rinc;
   logic                    flush = 1'b0;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [DSIZE*NBYTES-1:0] out_data;
   logic [CNT_W-1:0]        out_count;
   logic                    out_last;

   always #5 rclk = ~rclk;

   fifo_rd_packer #(
      .DSIZE  (DSIZE),
      .NBYTES (NBYTES),
      .CNT_W  (CNT_W)
   ) dut (
      .rclk      (rclk),
      .rrst      (rrst),
      .rempty    (rempty),
      .rdata     (rdata),
      .rinc      (rinc),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .out_last  (out_last)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [2:0]  count;
      logic        last;
   } word_t;

   word_t      exp_q[$];
   word_t      log_q[$];
   logic [7:0] fifo_q[$];
   logic [7:0] pend[$];
   bit         slot_full = 1'b0;
   bit         flushing  = 1'b0;
   int         tests = 0;
   int         fails = 0;
   int         ready_pct = 100;
   int         gap_pct = 0;
   int         flush_pct = 0;
   bit         force_flush = 1'b0;
   bit         last_rinc = 1'b0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   function automatic void check_log(string name, int idx, logic [31:0] d, int c, bit l);
      word_t w;
      w.data  = d;
      w.count = 3'(c);
      w.last  = l;
      if (idx >= log_q.size()) begin
         tests++;
         fails++;
         $display("FAIL %s: got no word, expected %0h", name, w);
      end else begin
         check(name, 64'(log_q[idx]), 64'(w));
      end
   endfunction

   // Closes the pending bytes into one expected word, first byte in lane 0.
   function automatic void emit(bit last);
      word_t w;
      w = '0;
      for (int i = 0; i < pend.size(); i++) w.data[i*8 +: 8] = pend[i];
      w.count = 3'(pend.size());
      w.last  = last;
      exp_q.push_back(w);
      pend.delete();
   endfunction

   // One cycle of the reference model, evaluated just before the clock edge.
   function automatic void model_step();
      bit can_load;
      bit xfer;
      bit pop;
      can_load = !slot_full || out_ready;
      xfer = 1'b0;
      pop  = 1'b0;
      check("out_valid", 64'(out_valid), 64'(slot_full));
      if (flushing) begin
         if (pend.size() == 0) begin
            flushing = 1'b0;
         end else if (can_load) begin
            emit(1'b1);
            xfer = 1'b1;
            flushing = 1'b0;
         end
      end else begin
         if (can_load && pend.size() == NBYTES) begin
            emit(1'b0);
            xfer = 1'b1;
         end
         pop = !rempty && (pend.size() < NBYTES);
         if (pop) pend.push_back(rdata);
         if (flush) flushing = 1'b1;
      end
      check("rinc", 64'(rinc), 64'(pop));
      slot_full = xfer ? 1'b1 : (out_ready ? 1'b0 : slot_full);
   endfunction

   task automatic step();
      @(negedge rclk);
      out_ready   = ($urandom_range(99) < ready_pct);
      flush       = force_flush || ($urandom_range(99) < flush_pct);
      force_flush = 1'b0;
      rempty      = (fifo_q.size() == 0) || ($urandom_range(99) < gap_pct);
      rdata       = rempty ? 8'h00 : fifo_q[0];
      #4;
      model_step();
      last_rinc = rinc;
      if (rinc && fifo_q.size() != 0) void'(fifo_q.pop_front());
   endtask

   task automatic do_reset();
      @(negedge rclk);
      #2;
      rrst = 1'b1;
      #1;
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_rinc", 64'(rinc), 64'(0));
      check("rst_data", 64'(out_data), 64'(0));
      check("rst_count_last", 64'({out_count, out_last}), 64'(0));
      pend.delete();
      exp_q.delete();
      slot_full = 1'b0;
      flushing  = 1'b0;
      rempty    = 1'b1;
      flush     = 1'b0;
      repeat (2) @(negedge rclk);
      rrst = 1'b0;
   endtask

   // Monitor: checks accepted words against the scoreboard and stability under stall.
   initial begin
      bit    held;
      word_t prev;
      word_t got;
      held = 1'b0;
      prev = '0;
      forever begin
         @(negedge rclk);
         #3;
         if (rrst) begin
            held = 1'b0;
         end else begin
            got.data  = out_data;
            got.count = out_count;
            got.last  = out_last;
            if (held) begin
               check("stall_valid", 64'(out_valid), 64'(1));
               check("stall_word", 64'(got), 64'(prev));
            end
            if (out_valid && out_ready) begin
               log_q.push_back(got);
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL out_word: got unexpected %0h, expected none", got);
               end else begin
                  check("out_word", 64'(got), 64'(exp_q.pop_front()));
               end
            end
            held = out_valid && !out_ready;
            prev = got;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      int ones;
      int first;
      int lastc;

      // Reset state with a non-empty FIFO presented.
      #7;
      check("init_valid", 64'(out_valid), 64'(0));
      check("init_rinc", 64'(rinc), 64'(0));
      check("init_out", 64'({out_data, out_count, out_last}), 64'(0));
      @(negedge rclk);
      rempty = 1'b1;
      rrst   = 1'b0;

      // T1: streaming, one pop per cycle.
      for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
      base = log_q.size();
      ones = 0;
      first = -1;
      lastc = -1;
      for (int c = 0; c < 14; c++) begin
         step();
         if (last_rinc) begin
            ones++;
            if (first < 0) first = c;
            lastc = c;
         end
      end
      check("t1_pops", 64'(ones), 64'(8));
      check("t1_contig", 64'(lastc - first), 64'(7));
      check_log("t1_w0", base, 32'h04030201, 4, 1'b0);
      check_log("t1_w1", base + 1, 32'h08070605, 4, 1'b0);

      // T2: back-pressure with 12 entries queued.
      ready_pct = 0;
      for (int i = 0; i < 12; i++) fifo_q.push_back(8'h10 + 8'(i));
      base = log_q.size();
      repeat (14) step();
      check("t2_left", 64'(fifo_q.size()), 64'(4));
      check("t2_rinc_off", 64'(last_rinc), 64'(0));
      check("t2_held", 64'(out_data), 64'(32'h13121110));
      ready_pct = 100;
      repeat (12) step();
      check_log("t2_w0", base, 32'h13121110, 4, 1'b0);
      check_log("t2_w1", base + 1, 32'h17161514, 4, 1'b0);
      check_log("t2_w2", base + 2, 32'h1b1a1918, 4, 1'b0);

      // T3: flush a two-entry word; no pop while flushing.
      fifo_q.push_back(8'haa);
      fifo_q.push_back(8'hbb);
      base = log_q.size();
      repeat (4) step();
      force_flush = 1'b1;
      step();
      fifo_q.push_back(8'hcc);
      step();
      check("t3_no_rinc", 64'(last_rinc), 64'(0));
      repeat (4) step();
      check_log("t3_word", base, 32'h0000bbaa, 2, 1'b1);

      // T4: flush coincident with a pop, then flush with an empty accumulator.
      fifo_q.push_back(8'hdd);
      base = log_q.size();
      force_flush = 1'b1;
      step();
      repeat (4) step();
      check_log("t4_coinc", base, 32'h0000ddcc, 2, 1'b1);
      base = log_q.size();
      force_flush = 1'b1;
      step();
      fifo_q.push_back(8'hee);
      step();
      step();
      check("t4_fill_resumes", 64'(last_rinc), 64'(1));
      repeat (3) step();
      check("t4_no_word", 64'(log_q.size() - base), 64'(0));
      base = log_q.size();
      force_flush = 1'b1;
      repeat (5) step();
      check_log("t4_single", base, 32'h000000ee, 1, 1'b1);

      // T5: reset with a held word and three entries accumulated.
      ready_pct = 0;
      for (int i = 0; i < 10; i++) fifo_q.push_back(8'h30 + 8'(i));
      repeat (7) step();
      check("t5_pre_valid", 64'(out_valid), 64'(1));
      do_reset();
      fifo_q.push_back(8'h3a);
      ready_pct = 100;
      base = log_q.size();
      repeat (8) step();
      check_log("t5_post", base, 32'h3a393837, 4, 1'b0);

      // T6: randomized traffic against the reference model.
      for (int ph = 0; ph < 6; ph++) begin
         ready_pct = int'($urandom_range(100, 20));
         gap_pct   = int'($urandom_range(60, 0));
         flush_pct = int'($urandom_range(8, 0));
         repeat (400) begin
            if (fifo_q.size() < 12 && $urandom_range(1) == 1) fifo_q.push_back(8'($urandom));
            step();
         end
      end
      ready_pct = 100;
      gap_pct   = 0;
      flush_pct = 0;
      repeat (40) step();
      force_flush = 1'b1;
      repeat (20) step();
      check("t6_drained", 64'(exp_q.size()), 64'(0));
      check("t6_pend", 64'(pend.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
